// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Brief    : Single-clock 16x oversampling UART receiver feeding a show-ahead
//            RX FIFO of {break, framing, parity, data} entries. The receive
//            timeout is built only when UART_RX_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
  parameter int MAX_DATA_BITS = 9,
  parameter int FIFO_DEPTH    = 16,
  parameter int DIV_W         = 16,
  parameter int TIMEOUT_BITS  = 32
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        rx_en,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [3:0]                  data_bits,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        stop_two,
  input  logic                        UART_RXD,
  input  logic                        rd_en,
  input  logic                        clr_overrun,
  output logic [MAX_DATA_BITS-1:0]    rd_data,
  output logic [2:0]                  rd_err,
  output logic                        rx_not_empty,
  output logic                        rx_fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overrun,
  output logic                        timeout_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = MAX_DATA_BITS + 3;
  localparam logic [AW:0]      LVL_ONE  = 1;
  localparam logic [AW:0]      LVL_FULL = FIFO_DEPTH[AW:0];
  localparam logic [AW-1:0]    PTR_ONE  = 1;
  localparam logic [DIV_W-1:0] DIV_ONE  = 1;

  if (MAX_DATA_BITS < 5 || MAX_DATA_BITS > 9 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DIV_W < 1 || TIMEOUT_BITS < 1) begin : g_param_check
    $error("uart_rx_core: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser and oversample prescaler
  // --------------------------------------------------------------------------
  logic [1:0]       sync_q;
  logic             rxs;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             start_det;

  assign rxs  = sync_q[1];
  assign tick = (div_q == '0);

  always_comb begin
    div_d = div_q - DIV_ONE;
    if (tick || start_det) div_d = baud_div;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      sync_q <= 2'b11;
      div_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], UART_RXD};
      div_q  <= div_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t                   state_q, state_d;
  logic [3:0]               os_q, os_d;
  logic [1:0]               samp_q, samp_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [MAX_DATA_BITS-1:0] data_q, data_d;
  logic                     par_err_q, par_err_d;
  logic                     frm_err_q, frm_err_d;
  logic                     zero_q, zero_d;
  logic                     stop2_q, stop2_d;
  logic                     bit_mid, bit_end, bit_val;
  logic                     push_req;
  logic [2:0]               push_err;

  assign bit_mid = tick && (os_q == 4'd9);
  assign bit_end = tick && (os_q == 4'd15);
  // 2-of-3 vote: samples from os=7 and os=8 plus the live value at os=9
  assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

  always_comb begin
    state_d   = state_q;
    os_d      = os_q;
    samp_d    = samp_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    zero_d    = zero_q;
    stop2_d   = stop2_q;
    start_det = 1'b0;
    push_req  = 1'b0;
    push_err  = 3'b000;

    if (state_q != S_IDLE && tick) begin
      os_d = os_q + 4'd1;
      if (os_q == 4'd7) samp_d[0] = rxs;
      if (os_q == 4'd8) samp_d[1] = rxs;
    end

    unique case (state_q)
      S_IDLE: begin
        if (rx_en && !rxs) begin
          state_d   = S_START;
          start_det = 1'b1;
          os_d      = 4'd0;
          bit_cnt_d = 4'd0;
          data_d    = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
          zero_d    = 1'b1;
          stop2_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_mid && bit_val)  state_d = S_IDLE;
        else if (bit_end)        state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_mid) begin
          for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (bit_cnt_q == 4'(i)) data_d[i] = bit_val;
          end
          if (bit_val) zero_d = 1'b0;
        end
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == data_bits - 4'd1) state_d = parity_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_mid) begin
          par_err_d = ((^data_q) ^ bit_val) != parity_odd;
          if (bit_val) zero_d = 1'b0;
        end
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_mid) begin
          frm_err_d = frm_err_q | ~bit_val;
          // only the first stop bit takes part in break detection
          if (!stop2_q) zero_d = zero_q & ~bit_val;
          if (!stop_two || stop2_q) begin
            push_req = 1'b1;
            push_err = {zero_d, frm_err_d, par_err_q};
            state_d  = rxs ? S_IDLE : S_WAIT_HIGH;
          end
        end else if (bit_end) begin
          stop2_d = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!rx_en) begin
      state_d  = S_IDLE;
      push_req = 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      os_q      <= 4'd0;
      samp_q    <= 2'b11;
      bit_cnt_q <= 4'd0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      zero_q    <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_q      <= os_d;
      samp_q    <= samp_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      zero_q    <= zero_d;
      stop2_q   <= stop2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead RX FIFO and sticky overrun
  // --------------------------------------------------------------------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          overrun_q;
  logic          fifo_empty, fifo_full, do_pop, do_push, ovr_set;
  logic [EW-1:0] head;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_FULL);
  assign do_pop     = rd_en && !fifo_empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push    = push_req && (!fifo_full || do_pop);
  assign ovr_set    = push_req && fifo_full && !do_pop;

  always_ff @(posedge PCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_err, data_q};
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      level_q <= level_q + LVL_ONE;
      else if (do_pop && !do_push) level_q <= level_q - LVL_ONE;
      if (ovr_set)          overrun_q <= 1'b1;
      else if (clr_overrun) overrun_q <= 1'b0;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign rd_data      = fifo_empty ? '0 : head[MAX_DATA_BITS-1:0];
  assign rd_err       = fifo_empty ? 3'b000 : head[EW-1 -: 3];
  assign rx_not_empty = !fifo_empty;
  assign rx_fifo_full = fifo_full;
  assign fifo_level   = level_q;
  assign overrun      = overrun_q;

  // --------------------------------------------------------------------------
  // Receive timeout
  // --------------------------------------------------------------------------
`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_TICKS = TIMEOUT_BITS * 16;
  localparam int TO_W     = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_TICKS - 1);
  localparam logic [TO_W-1:0] TO_ONE  = 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            to_flag_q;

  // counts oversample ticks, so TIMEOUT_BITS bit periods = TIMEOUT_BITS*16 ticks
  always_ff @(posedge PCLK) begin
    if (!PRESETn || !rx_en || rd_en || start_det) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else if (state_q == S_IDLE && rxs && !fifo_empty && tick && !to_flag_q) begin
      to_cnt_q <= to_cnt_q + TO_ONE;
      if (to_cnt_q == TO_LAST) to_flag_q <= 1'b1;
    end
  end

  assign timeout_flag = to_flag_q;
`else
  assign timeout_flag = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Brief    : Scoreboard bench for uart_rx_core (FIFO_DEPTH=4, baud_div=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

  localparam int BIT = 64;  // 16 ticks x (baud_div+1)

  logic       PCLK;
  logic       PRESETn;
  logic       rx_en;
  logic [15:0] baud_div;
  logic [3:0] data_bits;
  logic       parity_en, parity_odd, stop_two;
  logic       UART_RXD;
  logic       rd_en, clr_overrun;
  logic [8:0] rd_data;
  logic [2:0] rd_err;
  logic       rx_not_empty, rx_fifo_full, overrun, timeout_flag;
  logic [2:0] fifo_level;

  int n_chk = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  uart_rx_core #(
    .MAX_DATA_BITS (9),
    .FIFO_DEPTH    (4),
    .DIV_W         (16),
    .TIMEOUT_BITS  (4)
  ) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .rx_en        (rx_en),
    .baud_div     (baud_div),
    .data_bits    (data_bits),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .stop_two     (stop_two),
    .UART_RXD     (UART_RXD),
    .rd_en        (rd_en),
    .clr_overrun  (clr_overrun),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .rx_not_empty (rx_not_empty),
    .rx_fifo_full (rx_fifo_full),
    .fifo_level   (fifo_level),
    .overrun      (overrun),
    .timeout_flag (timeout_flag)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    repeat (60000) @(posedge PCLK);
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    UART_RXD = b;
    repeat (BIT) @(negedge PCLK);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input bit pe, input bit po,
                            input bit pflip, input bit sb, input bit two);
    logic p;
    drive_bit(1'b0);
    p = po;
    for (int i = 0; i < nb; i++) begin
      drive_bit(d[i]);
      p = p ^ d[i];
    end
    if (pe) drive_bit(pflip ? ~p : p);
    drive_bit(sb);
    if (two) drive_bit(1'b1);
  endtask

  task automatic set_fmt(input logic [3:0] nb, input bit pe, input bit po, input bit two);
    rx_en = 1'b0;
    @(negedge PCLK);
    data_bits  = nb;
    parity_en  = pe;
    parity_odd = po;
    stop_two   = two;
    @(negedge PCLK);
    rx_en = 1'b1;
    repeat (2) @(negedge PCLK);
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    @(negedge PCLK);
    rd_en = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic drain(input string tag);
    logic [11:0] e;
    int guard;
    guard = 0;
    while (rx_not_empty && guard < 8) begin
      guard++;
      if (exp_q.size() == 0) begin
        check_eq({tag, "_extra"}, 32'(rx_not_empty), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq({tag, "_data"}, 32'(rd_data), 32'(e[8:0]));
        check_eq({tag, "_err"},  32'(rd_err),  32'(e[11:9]));
      end
      pulse_rd();
    end
    check_eq({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_empty"}, 32'(rx_not_empty), 32'd0);
  endtask

  initial begin
    int n;
    PRESETn = 1'b0; rx_en = 1'b0; baud_div = 16'd3; data_bits = 4'd8;
    parity_en = 1'b0; parity_odd = 1'b0; stop_two = 1'b0;
    UART_RXD = 1'b1; rd_en = 1'b0; clr_overrun = 1'b0;
    repeat (4) @(negedge PCLK);
    check_eq("rst_data",  32'(rd_data),      32'd0);
    check_eq("rst_err",   32'(rd_err),       32'd0);
    check_eq("rst_ne",    32'(rx_not_empty), 32'd0);
    check_eq("rst_full",  32'(rx_fifo_full), 32'd0);
    check_eq("rst_level", 32'(fifo_level),   32'd0);
    check_eq("rst_ovr",   32'(overrun),      32'd0);
    check_eq("rst_to",    32'(timeout_flag), 32'd0);
    PRESETn = 1'b1;
    set_fmt(4'd8, 1'b0, 1'b0, 1'b0);

    // 8N1 0xA5 with push-latency window around the stop-bit mid-point
    exp_q.push_back({3'b000, 9'h0A5});
    n = 0;
    fork
      send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        while (!rx_not_empty && n < 800) begin
          @(negedge PCLK);
          n++;
        end
      end
    join
    check_eq("push_latency_ok", 32'(n >= 615 && n <= 623), 32'd1);
    check_eq("basic_level", 32'(fifo_level), 32'd1);
    drain("basic");

    // 9-bit odd parity, correct then inverted parity bit
    set_fmt(4'd9, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({3'b000, 9'h1FF});
    send_frame(9'h1FF, 9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({3'b001, 9'h1FF});
    send_frame(9'h1FF, 9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("par_level", 32'(fifo_level), 32'd2);
    drain("par");

    // 7E2 with zero padding above data_bits
    set_fmt(4'd7, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({3'b000, 9'h03C});
    send_frame(9'h03C, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("7e2");

    // framing error: stop bit low, line held low afterwards
    set_fmt(4'd8, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({3'b010, 9'h055});
    send_frame(9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2 * BIT) @(negedge PCLK);
    check_eq("frm_wait_level", 32'(fifo_level), 32'd1);
    UART_RXD = 1'b1;
    repeat (BIT) @(negedge PCLK);
    drain("frm");

    // break: line low for three frame times
    exp_q.push_back({3'b110, 9'h000});
    UART_RXD = 1'b0;
    repeat (30 * BIT) @(negedge PCLK);
    check_eq("brk_level", 32'(fifo_level), 32'd1);
    UART_RXD = 1'b1;
    repeat (2 * BIT) @(negedge PCLK);
    drain("brk");

    // overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back({3'b000, 9'(i)});
      send_frame(9'(i), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check_eq("ovr_level", 32'(fifo_level),   32'd4);
    check_eq("ovr_full",  32'(rx_fifo_full), 32'd1);
    check_eq("ovr_flag",  32'(overrun),      32'd1);
    drain("ovr");
    check_eq("ovr_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    @(negedge PCLK);
    clr_overrun = 1'b0;
    check_eq("ovr_clr", 32'(overrun), 32'd0);

    // glitch of five ticks is a false start
    UART_RXD = 1'b0;
    repeat (20) @(negedge PCLK);
    UART_RXD = 1'b1;
    repeat (20 * BIT) @(negedge PCLK);
    check_eq("glitch_level", 32'(fifo_level), 32'd0);

    // rx_en dropped mid-frame, then a clean frame after re-enable
    fork
      send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        repeat (5 * BIT) @(negedge PCLK);
        rx_en = 1'b0;
      end
    join
    rx_en = 1'b1;
    repeat (2 * BIT) @(negedge PCLK);
    check_eq("abort_level", 32'(fifo_level), 32'd0);
    exp_q.push_back({3'b000, 9'h0C3});
    send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("recover");

    // receive timeout
    exp_q.push_back({3'b000, 9'h07E});
    send_frame(9'h07E, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef UART_RX_TIMEOUT_EN
    repeat (150) @(negedge PCLK);
    check_eq("to_early", 32'(timeout_flag), 32'd0);
    n = 0;
    while (!timeout_flag && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    check_eq("to_set", 32'(timeout_flag), 32'd1);
    drain("to");
    check_eq("to_clr", 32'(timeout_flag), 32'd0);
`else
    repeat (400) @(negedge PCLK);
    check_eq("to_tied", 32'(timeout_flag), 32'd0);
    drain("to");
`endif

    // reset mid-frame with a stored entry
    exp_q.push_back({3'b000, 9'h011});
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("pre_rst_level", 32'(fifo_level), 32'd1);
    fork
      send_frame(9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        repeat (4 * BIT) @(negedge PCLK);
        PRESETn = 1'b0;
      end
    join
    check_eq("mrst_data",  32'(rd_data),      32'd0);
    check_eq("mrst_err",   32'(rd_err),       32'd0);
    check_eq("mrst_ne",    32'(rx_not_empty), 32'd0);
    check_eq("mrst_level", 32'(fifo_level),   32'd0);
    check_eq("mrst_ovr",   32'(overrun),      32'd0);
    check_eq("mrst_to",    32'(timeout_flag), 32'd0);
    PRESETn = 1'b1;
    exp_q.delete();
    repeat (2 * BIT) @(negedge PCLK);
    check_eq("post_rst_level", 32'(fifo_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised single-clock UART receiver replacing the fixed 8-bit receive path (start-bit detect, 12-bit shift register, 16-entry RX FIFO, separate baud clock domain). All logic runs on PCLK. An internal prescaler generates a 16x oversample enable, so no derived clock is needed. It receives 5 to MAX_DATA_BITS data bits with optional even/odd parity and 1 or 2 stop bits. Each frame is pushed, together with per-frame error flags, into a show-ahead FIFO that the APB register layer pops.

## Interface
Parameters:
- MAX_DATA_BITS, 9: widest supported frame payload; legal 5..9.
- FIFO_DEPTH, 16: RX FIFO entries; power of two, ≥2.
- DIV_W, 16: prescaler divisor width.
- TIMEOUT_BITS, 32: idle bit-times before timeout; used only with UART_RX_TIMEOUT_EN.

Ports:
- PCLK  in  1  sole clock; all state updates on the rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- rx_en  in  1  receiver enable.
- baud_div  in  DIV_W  oversample tick period minus one.
- data_bits  in  4  payload bit count, 5..MAX_DATA_BITS.
- parity_en / parity_odd / stop_two  in  1 each  frame format.
- UART_RXD  in  1  asynchronous serial input; idle high.
- rd_en  in  1  pop the FIFO head.
- clr_overrun  in  1  clear the sticky overrun flag.
- rd_data  out  MAX_DATA_BITS  FIFO head payload, zero-padded above data_bits.
- rd_err  out  3  FIFO head flags: {break, framing, parity}.
- rx_not_empty / rx_fifo_full  out  1 each  FIFO status.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entry count.
- overrun  out  1  sticky; a frame was dropped because the FIFO was full.
- timeout_flag  out  1  receive timeout.

## Operation
- **Synchroniser:** UART_RXD passes through 2 flops, reset to 1. All sampling uses the synchronised value rxs.
- **Prescaler:** a down-counter reloads baud_div and emits a one-cycle tick at 0. The tick period is baud_div+1 cycles, so baud_div=0 gives a tick every cycle. An oversample counter os counts 0..15 per bit, advancing on ticks.
- **States:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: rxs=0 → START, with os=0 and the prescaler reloaded.
  - Bit decision: each bit is a 2-of-3 majority of samples taken at os=7,8,9 and is decided at os=9. The state advances at os=15.
  - START: a majority of 1 is a false start → IDLE.
  - DATA: shifts LSB first for data_bits bits, then goes to PARITY if parity_en, else STOP.
  - PARITY: error if XOR(data, parity bit) ≠ parity_odd.
  - STOP: checks one stop bit, or two if stop_two. Any stop sample of 0 sets framing error.
  - Push: the entry is pushed at the os=9 decision of the final stop bit. The FSM then goes to IDLE if rxs=1, else to WAIT_HIGH.
  - WAIT_HIGH: waits for rxs=1, then → IDLE.
- **Break:** set when all data bits, the parity bit (if enabled) and the first stop bit are all 0. A break is pushed as a single entry with framing also set.
- **FIFO push/pop:**
  - Each entry is {err, data}. rd_data/rd_err always show the head; they are 0 when empty.
  - rd_en while empty is ignored.
  - Push while full drops the frame and sets overrun.
  - Push and pop in the same cycle while full: both are accepted, and overrun is not set.
- **Overrun clear:** clr_overrun clears overrun. If a set and a clear occur in the same cycle, the set wins.
- **rx_en=0:** the FSM returns to IDLE next cycle and any partial frame is discarded. FIFO contents and overrun are kept. Format inputs are changed only while rx_en=0.
- **Reset:** all outputs are 0, the FSM is IDLE, and FIFO pointers are 0. Reset mid-frame discards the frame.

## Timing
- Input latency: 2 PCLK cycles from UART_RXD to rxs.
- Bit period: 16×(baud_div+1) cycles.
- Push latency: rx_not_empty, fifo_level and rd_data update 1 cycle after the push decision tick.
- Pop latency: rd_en sampled high → head and level update on the same edge, with the new head visible next cycle.
- rx_fifo_full is asserted when fifo_level == FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

## Configuration
- **UART_RX_TIMEOUT_EN defined:**
  - A bit-time counter runs while FSM=IDLE, rxs=1 and rx_not_empty=1.
  - Reaching TIMEOUT_BITS bit periods sets timeout_flag.
  - The flag and counter clear on rd_en, on a detected start bit, or when rx_en=0.
- **Not defined:** timeout_flag is tied to 0 and no counter logic exists.

## Test plan
- **Basic 8N1:** baud_div=3, 8N1, send 0xA5 → rd_data=0x0A5, rd_err=000, fifo_level=1 one cycle after the stop-bit decision. rd_en → rx_not_empty=0.
- **9-bit odd parity:** send 0x1FF with a correct odd parity bit → rd_data=0x1FF, rd_err=000. Resend with the parity bit inverted → rd_err=001.
- **Framing and break:** 8N1, send 0x55 with stop=0 → rd_err=010, then WAIT_HIGH until the line rises. Hold the line low for 3 frames → exactly one entry, 0x000, rd_err=110.
- **Overrun:** FIFO_DEPTH=4, send 5 frames 0x01..0x05 with no pops → level=4, overrun=1, heads pop 0x01..0x04. clr_overrun → overrun=0.
- **Glitch and mid-frame abort:** a 5-tick low pulse → no entry, FSM back to IDLE. Drop rx_en mid-frame → no entry. Pull PRESETn low mid-frame → all outputs 0.
- **Timeout:** with UART_RX_TIMEOUT_EN, TIMEOUT_BITS=4 and baud_div=3, send one frame then idle → timeout_flag=1 after 256 idle cycles. rd_en clears it.
